fifo_rd_packer: RTL

Downstream read-side stage of the FIFO. Drains FIFO words through the FIFO's `rd_en`/`data_out` port, accounting for its one-cycle registered read latency. Packs pairs of FIFO words into double-width beats on a valid/ready output stream. Supports a flush request that emits a lone half-word with a byte-lane keep mask, and keeps a sticky error flag plus a beat counter for the verification environment.

---
 rtl/fifo_pkg.sv | 15 +
 rtl/fifo_rd_packer.sv | 132 +++++++++++++
 2 files changed

// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side packer.
package fifo_pkg;

    // Packer control states: no half held, low half held, beat held in output register.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HALF = 2'd1,
        OUT  = 2'd2
    } rdpk_state_e;

    // Byte-lane keep masks for the double-width output beat.
    localparam logic [1:0] KEEP_FULL = 2'b11;
    localparam logic [1:0] KEEP_LO   = 2'b01;

endpackage : fifo_pkg

// File: rtl/fifo_rd_packer.sv
// FIFO read-side packer: drains a FIFO with one-cycle read latency and packs
// pairs of words into double-width valid/ready beats, with a flush path that
// emits a lone low half-word. Also keeps a sticky underflow flag and a beat counter.
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    rd_en,
    input  logic [FIFO_WIDTH-1:0]   fifo_rdata,
    input  logic                    fifo_empty,
    input  logic                    fifo_underflow,
    input  logic                    flush,
    output logic [2*FIFO_WIDTH-1:0] m_data,
    output logic [1:0]              m_keep,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    err_underflow,
    output logic [CNT_WIDTH-1:0]    beat_cnt
);

    rdpk_state_e             r_state;
    rdpk_state_e             w_state_nxt;
    logic                    r_rd_pend;
    logic                    r_flush_pend;
    logic [FIFO_WIDTH-1:0]   r_lo;
    logic [2*FIFO_WIDTH-1:0] r_m_data;
    logic [1:0]              r_m_keep;
    logic                    r_err_underflow;
    logic [CNT_WIDTH-1:0]    r_beat_cnt;

    logic w_capture;
    logic w_serve_flush;
    logic w_drop_flush;
    logic w_accept;

    // A read issued last cycle means fifo_rdata holds its word this cycle.
    assign w_capture     = r_rd_pend;
    // A pending flush waits for any in-flight capture before emitting the held half.
    assign w_serve_flush = (r_state == HALF) && !r_rd_pend && r_flush_pend;
    // With nothing held and nothing in flight, a pending flush has nothing to emit.
    assign w_drop_flush  = (r_state == IDLE) && !r_rd_pend && r_flush_pend;
    assign w_accept      = (r_state == OUT) && m_ready;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: capture advances IDLE->HALF->OUT, flush shortcuts HALF->OUT.
    // NOTE: the default assignment first keeps this combinational block latch-free.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_capture)                     w_state_nxt = HALF;
            HALF:    if (w_capture || w_serve_flush)    w_state_nxt = OUT;
            OUT:     if (w_accept)                      w_state_nxt = IDLE;
            default:                                    w_state_nxt = IDLE;
        endcase
    end

    // Output logic: one read in flight at most, none while a beat or flush is pending.
    always_comb begin
        rd_en   = rst_n && !fifo_empty && !r_rd_pend && (r_state != OUT) && !r_flush_pend;
        m_valid = (r_state == OUT);
    end

    // Read/flush bookkeeping: rd_pend tracks the outstanding read, flush_pend latches flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_pend    <= 1'b0;
            r_flush_pend <= 1'b0;
        end else begin
            r_rd_pend <= rd_en;
            if (flush) begin
                r_flush_pend <= 1'b1;
            end else if (w_serve_flush || w_drop_flush) begin
                r_flush_pend <= 1'b0;
            end
        end
    end

    // Datapath: hold the low half, then build the output beat (full pair or flushed half).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lo     <= '0;
            r_m_data <= '0;
            r_m_keep <= '0;
        end else begin
            if ((r_state == IDLE) && w_capture) begin
                r_lo <= fifo_rdata;
            end
            if ((r_state == HALF) && w_capture) begin
                r_m_data <= {fifo_rdata, r_lo};
                r_m_keep <= KEEP_FULL;
            end else if (w_serve_flush) begin
                r_m_data <= {{FIFO_WIDTH{1'b0}}, r_lo};
                r_m_keep <= KEEP_LO;
            end
        end
    end

    // Status: sticky underflow flag and wrapping count of accepted beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_underflow <= 1'b0;
            r_beat_cnt      <= '0;
        end else begin
            if (fifo_underflow) begin
                r_err_underflow <= 1'b1;
            end
            if (w_accept) begin
                r_beat_cnt <= r_beat_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign m_data        = r_m_data;
    assign m_keep        = r_m_keep;
    assign err_underflow = r_err_underflow;
    assign beat_cnt      = r_beat_cnt;

endmodule : fifo_rd_packer
